// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS32 memory stage: access sizes,
// hold-register states and the byte-lane enable decoder.
package mips_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } mem_size_t;

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } hold_state_t;

    localparam int unsigned ERR_COUNT_W = 16;

    function automatic logic [3:0] byte_enables(input mem_size_t size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << lane;
            HALF:    be = lane[1] ? 4'b1100 : 4'b0011;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port synchronous word RAM with four byte-lane write enables,
// one-cycle read latency and write-first read data.
module byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] merged_s;

    // Word as it will look after this edge's write, returned on reads.
    always_comb begin
        merged_s = mem_r[addr];
        for (int i = 0; i < 4; i++) begin
            merged_s[8*i +: 8] = we[i] ? wdata[8*i +: 8] : mem_r[addr][8*i +: 8];
        end
    end

    // Lane writes and registered read port.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= merged_s;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Registered, stallable MIPS32 memory stage owning its data RAM: byte/half/word
// access, load extension, alignment/range checks and a stall hold register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int REG_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_e,
    output logic              ready_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic              mem_write_e,
    input  logic [1:0]        size_e,
    input  logic              unsigned_e,
    input  logic [DATA_W-1:0] alu_out_e,
    input  logic [DATA_W-1:0] write_data_e,
    input  logic [REG_W-1:0]  write_reg_e,
    input  logic              flush,
    output logic              valid_w,
    input  logic              ready_w,
    output logic [DATA_W-1:0] read_data_w,
    output logic [DATA_W-1:0] alu_out_w,
    output logic [REG_W-1:0]  write_reg_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic              err_w,
    output logic [15:0]       err_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_size_t         size_s;
    logic              accept_s, misaligned_s, out_of_range_s, err_s;
    logic              load_s, store_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s, ram_rdata_s, ext_s;
    logic [7:0]        lane_byte_s;
    logic [15:0]       lane_half_s;

    logic              valid_w_r, reg_write_w_r, mem_to_reg_w_r, err_w_r, unsigned_w_r;
    logic [DATA_W-1:0] alu_out_w_r, hold_r;
    logic [REG_W-1:0]  write_reg_w_r;
    mem_size_t         size_w_r;
    logic [15:0]       err_count_r;
    hold_state_t       state_r, state_next_s;

    assign size_s   = mem_size_t'(size_e);
    assign ready_e  = !valid_w_r || ready_w;
    assign accept_s = valid_e && ready_e;

    // Alignment and range checks on the execute-side address.
    always_comb begin
        case (size_s)
            BYTE:    misaligned_s = 1'b0;
            HALF:    misaligned_s = alu_out_e[0];
            WORD:    misaligned_s = (alu_out_e[1:0] != 2'b00);
            default: misaligned_s = 1'b1;
        endcase
        out_of_range_s = ({2'b00, alu_out_e[DATA_W-1:2]} >= DATA_W'(DEPTH_WORDS));
        err_s = (mem_to_reg_e || mem_write_e) && (misaligned_s || out_of_range_s);
    end

    assign load_s  = accept_s && mem_to_reg_e && !err_s;
    assign store_s = accept_s && mem_write_e && !err_s && !flush;
    assign be_s    = store_s ? byte_enables(size_s, alu_out_e[1:0]) : 4'b0000;

    // Replicate right-aligned store data onto every lane it may target.
    always_comb begin
        case (size_s)
            BYTE:    wdata_s = {4{write_data_e[7:0]}};
            HALF:    wdata_s = {2{write_data_e[15:0]}};
            default: wdata_s = write_data_e;
        endcase
    end

    byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (AW)
    ) u_ram (
        .clk  (clk),
        .en   (load_s || store_s),
        .we   (be_s),
        .addr (alu_out_e[2 +: AW]),
        .wdata(wdata_s),
        .rdata(ram_rdata_s)
    );

    assign lane_byte_s = ram_rdata_s[{alu_out_w_r[1:0], 3'b000} +: 8];
    assign lane_half_s = alu_out_w_r[1] ? ram_rdata_s[31:16] : ram_rdata_s[15:0];

    // Lane select and sign/zero extension of the RAM word for the W instruction.
    always_comb begin
        if (!valid_w_r || !mem_to_reg_w_r || err_w_r) begin
            ext_s = 32'h0000_0000;
        end else begin
            case (size_w_r)
                BYTE:    ext_s = {{24{lane_byte_s[7] & !unsigned_w_r}}, lane_byte_s};
                HALF:    ext_s = {{16{lane_half_s[15] & !unsigned_w_r}}, lane_half_s};
                default: ext_s = ram_rdata_s;
            endcase
        end
    end

    // Hold-register next state; flush always returns to live data.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LIVE:    state_next_s = (valid_w_r && !ready_w) ? HELD : LIVE;
            HELD:    state_next_s = ready_w ? LIVE : HELD;
            default: state_next_s = LIVE;
        endcase
        if (flush) begin
            state_next_s = LIVE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // M/W pipeline register, hold register and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_w_r      <= 1'b0;
            reg_write_w_r  <= 1'b0;
            mem_to_reg_w_r <= 1'b0;
            err_w_r        <= 1'b0;
            unsigned_w_r   <= 1'b0;
            alu_out_w_r    <= '0;
            write_reg_w_r  <= '0;
            size_w_r       <= BYTE;
            err_count_r    <= 16'h0000;
            hold_r         <= '0;
            state_r        <= LIVE;
        end else begin
            state_r <= state_next_s;
            if (flush) begin
                valid_w_r <= 1'b0;
            end else if (accept_s) begin
                valid_w_r <= 1'b1;
            end else if (ready_w) begin
                valid_w_r <= 1'b0;
            end
            if (accept_s) begin
                reg_write_w_r  <= reg_write_e && !err_s;
                mem_to_reg_w_r <= mem_to_reg_e;
                err_w_r        <= err_s;
                unsigned_w_r   <= unsigned_e;
                alu_out_w_r    <= alu_out_e;
                write_reg_w_r  <= write_reg_e;
                size_w_r       <= size_s;
            end
            if (accept_s && err_s && !flush && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
            end
            if (state_r == LIVE && valid_w_r && !ready_w) begin
                hold_r <= ext_s;
            end
        end
    end

    assign valid_w      = valid_w_r;
    assign read_data_w  = (state_r == HELD) ? hold_r : ext_s;
    assign alu_out_w    = alu_out_w_r;
    assign write_reg_w  = write_reg_w_r;
    assign reg_write_w  = reg_write_w_r;
    assign mem_to_reg_w = mem_to_reg_w_r;
    assign err_w        = err_w_r;
    assign err_count    = err_count_r;

endmodule
